pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage core.
- Collects stall requests from the IF, ID, EX and MEM stages and a flush (exception/eret) request.
- Drives the per-stage freeze vector consumed by the PC register and by the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, plus a registered flush pulse with the redirect PC.
- Defers a flush while a MEM-stage AXI transaction is in flight.

Parameters:
- PC_W, 32, width of redirect PC.
- FLUSH_CYCLES, 1, cycles flush stays asserted (1..15).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- stall_req_if  in  1  fetch waiting on instruction bus.
- stall_req_id  in  1  load-use hazard.
- stall_req_ex  in  1  multi-cycle mul/div busy.
- stall_req_mem  in  1  data bus transaction outstanding.
- flush_req  in  1  exception/eret detected in MEM; single-cycle pulse.
- flush_pc  in  PC_W  redirect target, valid with flush_req.
- stall  out  6  freeze vector: [0] PC, [1] IF_ID, [2] ID_EX, [3] EX_MEM, [4] MEM_WB, [5] WB (reserved, always 0).
- flush  out  1  clear all pipeline registers, redirect PC.
- new_pc  out  PC_W  redirect PC, valid while flush=1.
- busy_pend  out  1  flush latched but deferred.
- stall_cycles  out  32  see Optional Feature.

Behaviour:
- Reset (rst=0, async): state=RUN, flush=0, new_pc=0, busy_pend=0, flush counter=0, stall=6'b000000 (forced while rst=0).
- stall is combinational from the request inputs and the current state, with zero-cycle latency. Priority in RUN and PEND:
  - stall_req_mem → 6'b011111
  - else stall_req_ex → 6'b001111
  - else stall_req_id → 6'b000111
  - else stall_req_if → 6'b000011
  - else 6'b000000
- In FLUSH state, stall=6'b000000 regardless of requests.
- FSM states: RUN, PEND, FLUSH.
- RUN:
  - flush_req=1 and stall_req_mem=0 → FLUSH; latch new_pc<=flush_pc; flush<=1; counter<=FLUSH_CYCLES-1.
  - flush_req=1 and stall_req_mem=1 → PEND; latch new_pc<=flush_pc; busy_pend<=1.
  - Otherwise stay in RUN.
- PEND:
  - Further flush_req is ignored; the first target wins.
  - When stall_req_mem=0 (sampled at the clock edge) → FLUSH; flush<=1; busy_pend<=0; counter loaded.
- FLUSH:
  - flush=1 while counter counts down.
  - At counter=0, the next edge → RUN with flush<=0.
  - flush_req during FLUSH is ignored (the younger instruction is being squashed).
  - new_pc holds its value until the next latch.
- Latency: flush rises on the edge after flush_req (RUN case), or on the edge after stall_req_mem falls (PEND case).
- Simultaneous flush_req and stall_req_* in RUN: the stall vector applies in the same cycle; the flush is scheduled per the rules above.
- Reset asserted mid-FLUSH or mid-PEND: returns immediately to RUN; the latched target is discarded.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined: stall_cycles is a 32-bit counter, reset to 0.
  - Increments each cycle stall[0]=1.
  - Saturates at 32'hFFFFFFFF; no wrap.
- Undefined: stall_cycles is tied to 32'h0 and no counter logic is generated.

Test Plan:
- Reset then idle: rst low 3 cycles, then high with all requests 0 → stall=0, flush=0, new_pc=0, stall_cycles=0.
- Priority: stall_req_id=1 and stall_req_ex=1 in the same cycle → stall=6'b001111. Drop stall_req_ex → stall=6'b000111 in the same cycle.
- Immediate flush: flush_req=1, flush_pc=32'hBFC00380, mem idle → next cycle flush=1, new_pc=32'hBFC00380, stall=0. The cycle after, flush=0.
- Deferred flush: stall_req_mem=1 for 4 cycles with flush_req pulsed in cycle 1 (pc 32'h80000180), and a second flush_req in cycle 2 (pc 32'h1234) → busy_pend=1 for cycles 2–4, stall=6'b011111. flush=1 one cycle after stall_req_mem drops, with new_pc=32'h80000180.
- FLUSH_CYCLES=3: flush_req → flush high for exactly 3 cycles; a flush_req inside that window is ignored.
- With PIPE_STALL_CNT_EN: 10 cycles of stall_req_if=1 → stall_cycles=10. rst asserted mid-count → stall_cycles=0 asynchronously.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage core: per-stage freeze vector, deferred flush with redirect PC.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipeline_ctrl #(
   parameter int PC_W         = 32,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_req_if,
   input  logic            stall_req_id,
   input  logic            stall_req_ex,
   input  logic            stall_req_mem,
   input  logic            flush_req,
   input  logic [PC_W-1:0] flush_pc,
   output logic [5:0]      stall,
   output logic            flush,
   output logic [PC_W-1:0] new_pc,
   output logic            busy_pend,
   output logic [31:0]     stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_PEND,
      ST_FLUSH
   } state_e;

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_e          state_q, state_d;
   logic            flush_q, flush_d;
   logic [PC_W-1:0] new_pc_q, new_pc_d;
   logic            busy_q, busy_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [5:0]      stall_vec;

   // Freeze vector is purely combinational; held at zero while in reset or while flushing.
   always_comb begin
      stall_vec = 6'b000000;
      if (rst && (state_q != ST_FLUSH)) begin
         if (stall_req_mem)     stall_vec = 6'b011111;
         else if (stall_req_ex) stall_vec = 6'b001111;
         else if (stall_req_id) stall_vec = 6'b000111;
         else if (stall_req_if) stall_vec = 6'b000011;
      end
   end

   // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      flush_d  = flush_q;
      new_pc_d = new_pc_q;
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (flush_req) begin
               new_pc_d = flush_pc;
               if (stall_req_mem) begin
                  state_d = ST_PEND;
                  busy_d  = 1'b1;
               end else begin
                  state_d = ST_FLUSH;
                  flush_d = 1'b1;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         ST_PEND: begin
            // The first latched target wins; later requests are dropped.
            if (!stall_req_mem) begin
               state_d = ST_FLUSH;
               flush_d = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = CNT_LOAD;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RUN;
               flush_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            flush_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_RUN;
         flush_q  <= 1'b0;
         new_pc_q <= '0;
         busy_q   <= 1'b0;
         cnt_q    <= 4'd0;
      end else begin
         state_q  <= state_d;
         flush_q  <= flush_d;
         new_pc_q <= new_pc_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= 32'h0;
      end else if (stall_vec[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = 32'h0;
`endif

   assign stall     = stall_vec;
   assign flush     = flush_q;
   assign new_pc    = new_pc_q;
   assign busy_pend = busy_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: default instance plus a FLUSH_CYCLES=3 instance sharing stimulus.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
   logic        flush_req;
   logic [31:0] flush_pc;

   logic [5:0]  stall, stall3;
   logic        flush, flush3;
   logic [31:0] new_pc, new_pc3;
   logic        busy_pend, busy_pend3;
   logic [31:0] stall_cycles, stall_cycles3;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef PIPE_STALL_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   pipeline_ctrl #(.PC_W(32), .FLUSH_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
      .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
      .flush_req(flush_req), .flush_pc(flush_pc),
      .stall(stall), .flush(flush), .new_pc(new_pc),
      .busy_pend(busy_pend), .stall_cycles(stall_cycles)
   );

   pipeline_ctrl #(.PC_W(32), .FLUSH_CYCLES(3)) dut_fc3 (
      .clk(clk), .rst(rst),
      .stall_req_if(stall_req_if), .stall_req_id(stall_req_id),
      .stall_req_ex(stall_req_ex), .stall_req_mem(stall_req_mem),
      .flush_req(flush_req), .flush_pc(flush_pc),
      .stall(stall3), .flush(flush3), .new_pc(new_pc3),
      .busy_pend(busy_pend3), .stall_cycles(stall_cycles3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance one clock, then settle 1 time unit past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; stall_req_if = 1'b0; stall_req_id = 1'b0; stall_req_ex = 1'b0;
      stall_req_mem = 1'b1; flush_req = 1'b0; flush_pc = 32'h0;
      #1;
      check("stall_forced_in_reset", {26'h0, stall}, 32'h0);
      stall_req_mem = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      #1;
      check("idle_stall", {26'h0, stall}, 32'h0);
      check("idle_flush", {31'h0, flush}, 32'h0);
      check("idle_new_pc", new_pc, 32'h0);
      check("idle_busy", {31'h0, busy_pend}, 32'h0);
      check("idle_cnt", stall_cycles, 32'h0);

      // Priority, all within one cycle
      stall_req_id = 1'b1; stall_req_ex = 1'b1; #1;
      check("prio_ex_id", {26'h0, stall}, 32'h0F);
      stall_req_ex = 1'b0; #1;
      check("prio_id", {26'h0, stall}, 32'h07);
      stall_req_id = 1'b0; stall_req_if = 1'b1; #1;
      check("prio_if", {26'h0, stall}, 32'h03);
      stall_req_mem = 1'b1; #1;
      check("prio_mem", {26'h0, stall}, 32'h1F);
      stall_req_mem = 1'b0; stall_req_if = 1'b0; #1;
      check("prio_none", {26'h0, stall}, 32'h0);

      // Immediate flush
      flush_req = 1'b1; flush_pc = 32'hBFC00380; #1;
      check("imm_flush_not_yet", {31'h0, flush}, 32'h0);
      step();
      flush_req = 1'b0; stall_req_if = 1'b1; #1;
      check("imm_flush_hi", {31'h0, flush}, 32'h1);
      check("imm_new_pc", new_pc, 32'hBFC00380);
      check("imm_stall_zero", {26'h0, stall}, 32'h0);
      step();
      check("imm_flush_lo", {31'h0, flush}, 32'h0);
      check("imm_pc_hold", new_pc, 32'hBFC00380);
      check("imm_stall_back", {26'h0, stall}, 32'h03);
      stall_req_if = 1'b0;
      repeat (3) step();

      // Deferred flush
      stall_req_mem = 1'b1; flush_req = 1'b1; flush_pc = 32'h80000180; #1;
      check("def_c1_stall", {26'h0, stall}, 32'h1F);
      check("def_c1_busy", {31'h0, busy_pend}, 32'h0);
      step();
      flush_pc = 32'h00001234; #1;
      check("def_c2_busy", {31'h0, busy_pend}, 32'h1);
      check("def_c2_flush", {31'h0, flush}, 32'h0);
      check("def_c2_stall", {26'h0, stall}, 32'h1F);
      step();
      flush_req = 1'b0; #1;
      check("def_c3_busy", {31'h0, busy_pend}, 32'h1);
      step();
      check("def_c4_busy", {31'h0, busy_pend}, 32'h1);
      check("def_c4_pc", new_pc, 32'h80000180);
      stall_req_mem = 1'b0; #1;
      check("def_c5_stall", {26'h0, stall}, 32'h0);
      check("def_c5_flush", {31'h0, flush}, 32'h0);
      step();
      check("def_flush_hi", {31'h0, flush}, 32'h1);
      check("def_new_pc", new_pc, 32'h80000180);
      check("def_busy_clr", {31'h0, busy_pend}, 32'h0);
      step();
      check("def_flush_lo", {31'h0, flush}, 32'h0);
      repeat (4) step();

      // Three-cycle flush window on the second instance
      flush_req = 1'b1; flush_pc = 32'h00000100;
      step();
      flush_pc = 32'h00000200; #1;
      check("fc3_cyc1", {31'h0, flush3}, 32'h1);
      check("fc3_stall0", {26'h0, stall3}, 32'h0);
      step();
      flush_req = 1'b0; #1;
      check("fc3_cyc2", {31'h0, flush3}, 32'h1);
      check("fc3_pc", new_pc3, 32'h00000100);
      check("fc1_ignored_lo", {31'h0, flush}, 32'h0);
      step();
      check("fc3_cyc3", {31'h0, flush3}, 32'h1);
      check("fc1_ignored_pc", new_pc, 32'h00000100);
      step();
      check("fc3_done", {31'h0, flush3}, 32'h0);
      check("fc3_pc_hold", new_pc3, 32'h00000100);
      step();
      check("fc3_ignored", {31'h0, flush3}, 32'h0);

      // Reset mid-PEND discards the target
      stall_req_mem = 1'b1; flush_req = 1'b1; flush_pc = 32'hDEAD0000;
      step();
      flush_req = 1'b0; #1;
      check("pend_busy", {31'h0, busy_pend}, 32'h1);
      rst = 1'b0; #1;
      check("rst_pend_busy", {31'h0, busy_pend}, 32'h0);
      check("rst_pend_pc", new_pc, 32'h0);
      check("rst_pend_stall", {26'h0, stall}, 32'h0);
      step();
      rst = 1'b1; stall_req_mem = 1'b0;
      step();
      check("rst_pend_noflush", {31'h0, flush}, 32'h0);
      check("rst_pend_noflush3", {31'h0, flush3}, 32'h0);

      // Stall-cycle counter
      rst = 1'b0; #1; rst = 1'b1; #1;
      stall_req_if = 1'b1;
      repeat (10) step();
      stall_req_if = 1'b0; #1;
      check("cnt_10", stall_cycles, CNT_EN ? 32'd10 : 32'd0);
      step();
      check("cnt_hold", stall_cycles, CNT_EN ? 32'd10 : 32'd0);
      stall_req_ex = 1'b1;
      repeat (3) step();
      check("cnt_13", stall_cycles, CNT_EN ? 32'd13 : 32'd0);
      rst = 1'b0; #1;
      check("cnt_async_rst", stall_cycles, 32'd0);
      stall_req_ex = 1'b0;
      step();
      rst = 1'b1;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
